ladybird_bus_arbiter: RTL
=========================

# ladybird_bus_arbiter

Two-requester, single-target memory bus arbiter for the ladybird core. It shares one memory port between the instruction-fetch requester (port 0) and the MMU data requester (port 1). Arbitration is round-robin. The block tracks the owner of every outstanding transaction in an in-order owner FIFO and routes each response back to the requester that issued it. It sits between `ladybird_core`/`ladybird_mmu` and the memory or bus target.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `OUTSTANDING`, 2: depth of the owner FIFO, i.e. the maximum number of accepted but unanswered requests. Legal range 1..8.

Ports (`<i>` is 0 for instruction fetch, 1 for data):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `anrst`  in  1  asynchronous, active-low reset.
- `nrst`  in  1  synchronous, active-low clear; same effect as `anrst`, sampled on `clk`.
- `m<i>_req`  in  1  request from requester i.
- `m<i>_gnt`  out  1  request from requester i accepted this cycle.
- `m<i>_addr`  in  XLEN  request address.
- `m<i>_wdata`  in  XLEN  write data.
- `m<i>_wstrb`  in  XLEN/8  byte write strobes; all zero means read.
- `m<i>_rdata`  out  XLEN  response data; broadcast copy of `s_rdata`.
- `m<i>_rvalid`  out  1  response for requester i is valid this cycle.
- `s_req`  out  1  request to the target.
- `s_gnt`  in  1  target accepts `s_req` this cycle.
- `s_addr`, `s_wdata`, `s_wstrb`  out  XLEN / XLEN / XLEN/8  winner's request fields.
- `s_rdata`  in  XLEN  target response data.
- `s_rvalid`  in  1  target response valid; exactly one per accepted request, reads and writes alike, returned in order.
- `busy`  out  1  high when the owner FIFO is non-empty.
- `err`  out  1  sticky protocol-error flag.

## Operation
- State:
  - `last` (1 bit): owner of the most recent grant.
  - Owner FIFO: `OUTSTANDING` entries × 1 bit, with read pointer, write pointer and count.
  - `err`.
- Winner selection (combinational):
  - Only one requester active: that requester wins.
  - Both active: the requester other than `last` wins.
  - Neither active: `winner` = 0, and its fields drive `s_*` as don't-care.
- `full` = (count == OUTSTANDING).
- `s_req` = (m0_req | m1_req) & ~full.
- `s_addr`, `s_wdata`, `s_wstrb` are muxed from the winner.
- Handshake `hs` = s_req & s_gnt. Then `m<winner>_gnt` = hs, and the other requester's `gnt` = 0.
- On `hs`:
  - Push `winner` into the owner FIFO.
  - `last` <= winner.
- On `s_rvalid` with count > 0:
  - `m<head>_rvalid` = 1 and the other `rvalid` = 0.
  - Pop the FIFO head.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full FIFO: `s_req` forced to 0 even if a pop happens that cycle. No bypass.
- `s_rvalid` while count == 0:
  - No `m_rvalid` is asserted and FIFO state is unchanged.
  - `err` <= 1 and holds until reset.
- Pointers wrap modulo `OUTSTANDING`. Count is a `$clog2(OUTSTANDING+1)`-bit value and never exceeds `OUTSTANDING`.
- Requesters must hold `req` and the request fields stable until `gnt`. The winner cannot change while `s_gnt` is low, because `last` only updates on `hs`.

## Timing
- Reset (`anrst` low, or `nrst` low at an edge):
  - count = 0, pointers = 0, `last` = 1 (port 0 wins the first tie), `err` = 0.
  - With no requests pending: all `gnt`/`rvalid` = 0, `s_req` = 0, `busy` = 0.
- Reset during operation discards all outstanding ownership. Any `s_rvalid` that arrives afterwards sets `err`.
- Arbitration, grant and response routing are purely combinational: zero added latency on request and response.
- A response may return in the same cycle as the next grant.
- FIFO and `last` updates become visible the cycle after the event.

## Test plan
- Reset, then m0_req=1 addr=0x100 with s_gnt=1 → m0_gnt=1, s_addr=0x100, busy=1 next cycle. s_rvalid=1 with s_rdata=0xDEADBEEF → m0_rvalid=1, m0_rdata=0xDEADBEEF, busy=0 next cycle.
- Both requesting, s_gnt held high, immediate responses each cycle → grants alternate m0, m1, m0, m1 (first tie to m0). Each `rvalid` goes to the matching port.
- OUTSTANDING=2, two grants with no response → third cycle: s_req=0 with both requests pending. s_rvalid in that cycle → s_req stays 0 that cycle, then reasserts.
- s_gnt=0 for 5 cycles while both request → s_addr held on m0's address throughout. Grant on cycle 6 goes to m0.
- Stray s_rvalid with FIFO empty → no m_rvalid, err=1 and sticky; nrst low one cycle → err=0.
- Issue m1 write (wstrb=0001) then m0 read; pulse anrst before the responses return → count=0 and busy=0 immediately. A later s_rvalid sets err=1.

Source files
------------

// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and MMU.
// An in-order owner FIFO routes each response back to its requester.
module ladybird_bus_arbiter #(
   parameter int XLEN        = 32,
   parameter int OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              anrst,
   input  logic              nrst,
   input  logic              m0_req,
   output logic              m0_gnt,
   input  logic [XLEN-1:0]   m0_addr,
   input  logic [XLEN-1:0]   m0_wdata,
   input  logic [XLEN/8-1:0] m0_wstrb,
   output logic [XLEN-1:0]   m0_rdata,
   output logic              m0_rvalid,
   input  logic              m1_req,
   output logic              m1_gnt,
   input  logic [XLEN-1:0]   m1_addr,
   input  logic [XLEN-1:0]   m1_wdata,
   input  logic [XLEN/8-1:0] m1_wstrb,
   output logic [XLEN-1:0]   m1_rdata,
   output logic              m1_rvalid,
   output logic              s_req,
   input  logic              s_gnt,
   output logic [XLEN-1:0]   s_addr,
   output logic [XLEN-1:0]   s_wdata,
   output logic [XLEN/8-1:0] s_wstrb,
   input  logic [XLEN-1:0]   s_rdata,
   input  logic              s_rvalid,
   output logic              busy,
   output logic              err
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);

   logic                   last_q, last_d;
   logic                   err_q, err_d;
   logic [OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d;

   logic winner;
   logic full;
   logic hs;
   logic pop;
   logic head;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   // On a tie the requester that did not win last time goes next.
   assign winner = m1_req & (~m0_req | ~last_q);
   assign full   = (count_q == CW'(OUTSTANDING));
   assign s_req  = (m0_req | m1_req) & ~full;
   assign hs     = s_req & s_gnt;
   assign pop    = s_rvalid & (count_q != '0);
   assign head   = fifo_q[rd_ptr_q];

   assign s_addr  = winner ? m1_addr  : m0_addr;
   assign s_wdata = winner ? m1_wdata : m0_wdata;
   assign s_wstrb = winner ? m1_wstrb : m0_wstrb;

   assign m0_gnt    = hs & ~winner;
   assign m1_gnt    = hs & winner;
   assign m0_rvalid = pop & ~head;
   assign m1_rvalid = pop & head;
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;

   assign busy = (count_q != '0);
   assign err  = err_q;

   always_comb begin
      last_d   = last_q;
      err_d    = err_q;
      fifo_d   = fifo_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (hs) begin
         fifo_d[wr_ptr_q] = winner;
         wr_ptr_d         = ptr_next(wr_ptr_q);
         last_d           = winner;
      end
      if (pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
      unique case ({hs, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (s_rvalid && (count_q == '0)) begin
         err_d = 1'b1;
      end
      if (!nrst) begin
         last_d   = 1'b1;
         err_d    = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         last_q   <= 1'b1;
         err_q    <= 1'b0;
         fifo_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         last_q   <= last_d;
         err_q    <= err_d;
         fifo_q   <= fifo_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
